// File: rtl/packet_demultiplexer.sv
// 1-to-4 packet router: steers a valid/ready stream to one of four registered
// output channels, holding the route until the last beat of each packet.
module packet_demultiplexer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_last,
  input  logic                 address0,
  input  logic                 address1,
  output logic [3:0]           out_valid,
  input  logic [3:0]           out_ready,
  output logic [4*WIDTH-1:0]   out_data,
  output logic [3:0]           out_last,
  output logic [4*CNT_W-1:0]   beat_count,
  output logic                 busy
);

  // state | meaning
  // IDLE  | between packets, route taken from the address inputs
  // ROUTE | mid-packet, route held in the latched register
  typedef enum logic {IDLE = 1'b0, ROUTE = 1'b1} state_t;

  state_t     state;
  logic [1:0] route;
  logic [1:0] target;
  logic       accept;

  assign target   = (state == ROUTE) ? route : {address1, address0};
  assign in_ready = !out_valid[target] | out_ready[target];
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      route <= 2'd0;
      busy  <= 1'b0;
    end else if (accept) begin
      case (state)
        IDLE: begin
          if (!in_last) begin
            state <= ROUTE;
            route <= target;
            busy  <= 1'b1;
          end
        end
        ROUTE: begin
          if (in_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar n = 0; n < 4; n++) begin : g_chan
    logic             valid_q;
    logic             last_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] count_q;
    logic             load;
    logic             deliver;

    assign load    = accept && (target == 2'(n));
    assign deliver = valid_q & out_ready[n];

    // A load in the same cycle as a drain replaces the outgoing beat.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
        count_q <= '0;
      end else begin
        if (load) begin
          valid_q <= 1'b1;
          data_q  <= in_data;
          last_q  <= in_last;
        end else if (deliver) begin
          valid_q <= 1'b0;
        end
        if (deliver) count_q <= count_q + CNT_W'(1);
      end
    end

    assign out_valid[n]                   = valid_q;
    assign out_last[n]                    = last_q;
    assign out_data[n*WIDTH +: WIDTH]     = data_q;
    assign beat_count[n*CNT_W +: CNT_W]   = count_q;
  end

endmodule

// File: tb/tb_packet_demultiplexer.sv
// Randomized bench for packet_demultiplexer with a per-channel behavioural model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_packet_demultiplexer;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             address0 = 1'b0;
  logic             address1 = 1'b0;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'hF;
  logic [4*WIDTH-1:0] out_data;
  logic [3:0]       out_last;
  logic [4*CNT_W-1:0] beat_count;
  logic             busy;

  int checks = 0;
  int errors = 0;

  packet_demultiplexer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .address0(address0), .address1(address1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .beat_count(beat_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: one holding slot per channel, a packet flag and its route.
  bit         started = 0;
  bit         m_valid [4];
  bit         m_last  [4];
  logic [7:0] m_data  [4];
  logic [7:0] m_count [4];
  bit         m_in_pkt;
  logic [1:0] m_route;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] m_target();
    return m_in_pkt ? m_route : {address1, address0};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      started = 1;
      m_in_pkt = 0;
      m_route = 2'd0;
      for (int n = 0; n < 4; n++) begin
        m_valid[n] = 0; m_last[n] = 0; m_data[n] = 8'h00; m_count[n] = 8'h00;
      end
    end else if (started) begin
      logic [1:0] tgt;
      bit acc;
      tgt = m_target();
      acc = in_valid && (!m_valid[tgt] || out_ready[tgt]);
      for (int n = 0; n < 4; n++) begin
        if (m_valid[n] && out_ready[n]) begin
          m_count[n] = m_count[n] + 8'd1;
          m_valid[n] = 0;
        end
      end
      if (acc) begin
        m_valid[tgt] = 1;
        m_data[tgt]  = in_data;
        m_last[tgt]  = in_last;
        if (!m_in_pkt && !in_last) begin
          m_in_pkt = 1;
          m_route  = tgt;
        end else if (m_in_pkt && in_last) begin
          m_in_pkt = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      logic [3:0]  ev, el;
      logic [31:0] ed, ec;
      logic [1:0]  tgt;
      for (int n = 0; n < 4; n++) begin
        ev[n] = m_valid[n];
        el[n] = m_last[n];
        ed[n*8 +: 8] = m_data[n];
        ec[n*8 +: 8] = m_count[n];
      end
      tgt = m_target();
      chk("in_ready",   {31'd0, in_ready},  {31'd0, (!m_valid[tgt] || out_ready[tgt])});
      chk("out_valid",  {28'd0, out_valid}, {28'd0, ev});
      chk("out_last",   {28'd0, out_last},  {28'd0, el});
      chk("out_data",   out_data,           ed);
      chk("beat_count", beat_count,         ec);
      chk("busy",       {31'd0, busy},      {31'd0, m_in_pkt});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [1:0] a, input logic [7:0] d, input bit l);
    in_valid = v;
    {address1, address0} = a;
    in_data = d;
    in_last = l;
  endtask

  initial begin
    logic [7:0] b;
    drive(0, 2'd0, 8'h00, 0);
    tick(); tick();
    reset = 0;
    chk("reset_valid", {28'd0, out_valid}, 32'd0);
    chk("reset_count", beat_count, 32'd0);

    // 1: single-beat packet to channel 2
    drive(1, 2'd2, 8'hA5, 1);
    tick();
    drive(0, 2'd0, 8'h00, 0);
    chk("t1_valid", {28'd0, out_valid}, 32'h4);
    b = out_data[23:16];
    chk("t1_data", {24'd0, b}, 32'hA5);
    chk("t1_last", {31'd0, out_last[2]}, 32'd1);
    chk("t1_busy", {31'd0, busy}, 32'd0);
    tick();
    b = beat_count[23:16];
    chk("t1_count2", {24'd0, b}, 32'd1);

    // 2: three beats to ch1, address moves to 3 after the first
    drive(1, 2'd1, 8'h11, 0);
    tick();
    chk("t2_busy1", {31'd0, busy}, 32'd1);
    b = out_data[15:8];
    chk("t2_d1", {24'd0, b}, 32'h11);
    drive(1, 2'd3, 8'h22, 0);
    tick();
    b = out_data[15:8];
    chk("t2_d2", {24'd0, b}, 32'h22);
    chk("t2_v2", {28'd0, out_valid}, 32'h2);
    drive(1, 2'd3, 8'h33, 1);
    tick();
    drive(0, 2'd0, 8'h00, 0);
    b = out_data[15:8];
    chk("t2_d3", {24'd0, b}, 32'h33);
    chk("t2_v3", {28'd0, out_valid}, 32'h2);
    chk("t2_busy3", {31'd0, busy}, 32'd0);
    tick();

    // 3: backpressure on ch0
    out_ready = 4'b1110;
    drive(1, 2'd0, 8'h40, 0);
    tick();
    drive(1, 2'd0, 8'h41, 1);
    #1 chk("t3_stall_rdy", {31'd0, in_ready}, 32'd0);
    tick(); tick();
    b = out_data[7:0];
    chk("t3_hold", {24'd0, b}, 32'h40);
    chk("t3_hold_v", {31'd0, out_valid[0]}, 32'd1);
    out_ready = 4'hF;
    #1 chk("t3_release_rdy", {31'd0, in_ready}, 32'd1);
    tick();
    drive(0, 2'd0, 8'h00, 0);
    b = out_data[7:0];
    chk("t3_second", {24'd0, b}, 32'h41);
    chk("t3_second_v", {31'd0, out_valid[0]}, 32'd1);
    tick();

    // 4: ch0 stalled while ch3 streams
    out_ready = 4'b1110;
    drive(1, 2'd0, 8'h50, 1);
    tick();
    out_ready = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'd3, 8'h60 + 8'(i), (i == 3));
      #1 chk("t4_rdy", {31'd0, in_ready}, 32'd1);
      tick();
      b = out_data[31:24];
      chk("t4_ch3", {24'd0, b}, 32'h60 + i);
      b = out_data[7:0];
      chk("t4_ch0_held", {24'd0, b}, 32'h50);
    end
    drive(0, 2'd0, 8'h00, 0);
    out_ready = 4'hF;
    tick(); tick();

    // 5: counter wrap on ch1
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 256; i++) begin
      drive(1, 2'd1, 8'(i), 1);
      tick();
    end
    drive(0, 2'd0, 8'h00, 0);
    tick(); tick();
    chk("t5_wrap", beat_count, 32'd0);

    // 6: reset mid-packet with ch2 full
    drive(1, 2'd3, 8'h12, 1);
    tick();
    out_ready = 4'b1011;
    drive(1, 2'd2, 8'h77, 0);
    tick();
    drive(0, 2'd0, 8'h00, 0);
    chk("t6_busy_pre", {31'd0, busy}, 32'd1);
    chk("t6_cnt_pre", beat_count, 32'h0100_0000);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_valid", {28'd0, out_valid}, 32'd0);
    chk("t6_busy", {31'd0, busy}, 32'd0);
    chk("t6_count", beat_count, 32'd0);
    out_ready = 4'hF;
    drive(1, 2'd0, 8'h88, 1);
    tick();
    drive(0, 2'd0, 8'h00, 0);
    chk("t6_route", {28'd0, out_valid}, 32'h1);
    b = out_data[7:0];
    chk("t6_data", {24'd0, b}, 32'h88);

    // Random traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 299) == 0);
      drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 8'($urandom),
            $urandom_range(0, 2) == 0);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 3) == 0) out_ready = 4'hF;
      tick();
    end
    reset = 0;
    drive(0, 2'd0, 8'h00, 0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
